// File: rtl/rx_deserializer_if.sv
// Parallel flit handshake between the link receiver and the router input logic.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

interface rx_deserializer_if;
  localparam int unsigned W = `PAYLOAD_SIZE + `ADDR_BITS;

  logic [W-1:0] parallel_out;
  logic         valid;
  logic         ack;

  modport master (output parallel_out, output valid, input ack);
  modport slave  (input parallel_out, input valid, output ack);
endinterface

// File: rtl/rx_deserializer.sv
// Single-wire flit link receiver: start-bit detect, LSB-first shift-in,
// parallel delivery with valid/ack and a busy indication back to the sender.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module rx_deserializer #(
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                serial_in,
  rx_deserializer_if.master   flit_bus,
  output logic                channel_busy,
  output logic                rx_active,
  output logic                overflow
);

  localparam int unsigned W  = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int unsigned CW = $clog2(W);

  // Debug labels only; kept referenced so they stay visible in elaboration.
  localparam bit dbg_unused = (routerid > -1) && (port != "");

  typedef enum logic {IDLE, RECV} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [W-1:0]   flit_q, flit_d;
  logic           valid_q, valid_d;
  logic           rx_active_q, rx_active_d;
  logic           overflow_q, overflow_d;
  logic [W-1:0]   new_flit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      flit_q      <= '0;
      valid_q     <= 1'b0;
      rx_active_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      flit_q      <= flit_d;
      valid_q     <= valid_d;
      rx_active_q <= rx_active_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    flit_d      = flit_q;
    valid_d     = valid_q;
    rx_active_d = rx_active_q;
    overflow_d  = 1'b0;
    new_flit    = {serial_in, shreg_q[W-1:1]};

    if (valid_q && flit_bus.ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (serial_in) begin
          state_d     = RECV;
          bit_cnt_d   = '0;
          rx_active_d = 1'b1;
        end
      end
      RECV: begin
        shreg_d   = new_flit;
        bit_cnt_d = bit_cnt_q + CW'(1);
        // The counter alone frames the flit; line content is never checked.
        if (bit_cnt_q == CW'(W - 1)) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          rx_active_d = 1'b0;
          // A completion may replace a flit only if it is being acked now.
          if (!valid_q || flit_bus.ack) begin
            flit_d  = new_flit;
            valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flit_bus.parallel_out = flit_q;
  assign flit_bus.valid        = valid_q;
  assign rx_active             = rx_active_q;
  assign overflow              = overflow_q;
  assign channel_busy          = rx_active_q | valid_q;

endmodule
